// File: rtl/one_bit_adder_if.sv
// Purpose: operand/control and result bundle for the one-bit adder cell.
// Latency: none; wiring only.
// Backpressure: none; the cell accepts a bit every cycle.
interface one_bit_adder_if #(
  parameter int WORD_W = 8
);
  localparam int CNT_W = $clog2(WORD_W + 1);

  // Operand and control bits driven by the ALU side
  logic              in_1;
  logic              in_2;
  logic              c_in;
  logic              ser_en;
  logic              ser_clr;

  // Combinational, registered and serial results
  logic              sum;
  logic              c_out;
  logic              sum_q;
  logic              c_out_q;
  logic              ser_sum;
  logic              carry_q;
  logic [WORD_W-1:0] ser_word;
  logic [CNT_W-1:0]  bit_count;
  logic              ser_done;

  modport master (
    output in_1, in_2, c_in, ser_en, ser_clr,
    input  sum, c_out, sum_q, c_out_q, ser_sum, carry_q,
           ser_word, bit_count, ser_done
  );

  modport slave (
    input  in_1, in_2, c_in, ser_en, ser_clr,
    output sum, c_out, sum_q, c_out_q, ser_sum, carry_q,
           ser_word, bit_count, ser_done
  );
endinterface

// File: rtl/one_bit_adder.sv
// Purpose: full-adder cell with registered copies and an LSB-first bit-serial adder.
// Latency: sum/c_out/ser_sum 0 cycles; sum_q/c_out_q 1 cycle; serial word after WORD_W enables.
// Backpressure: none; once bit_count saturates, further ser_en pulses are ignored.
module one_bit_adder #(
  parameter int WORD_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  one_bit_adder_if.slave  bus
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W);

  logic              sum_c;
  logic              c_out_c;
  logic              ser_sum_c;
  logic              ser_carry_c;
  logic              sum_r;
  logic              c_out_r;
  logic              carry_r;
  logic [WORD_W-1:0] word_r;
  logic [CNT_W-1:0]  count_r;
  logic              full;

  assign full = (count_r == CNT_MAX);

  // Full-adder functions: plain path uses c_in, serial path uses the carry flop
  always_comb begin
    sum_c       = bus.in_1 ^ bus.in_2 ^ bus.c_in;
    c_out_c     = (bus.in_1 & bus.in_2) | (bus.in_1 & bus.c_in) | (bus.in_2 & bus.c_in);
    ser_sum_c   = bus.in_1 ^ bus.in_2 ^ carry_r;
    ser_carry_c = (bus.in_1 & bus.in_2) | (bus.in_1 & carry_r) | (bus.in_2 & carry_r);
  end

  // Registered copies of the combinational outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= 1'b0;
      c_out_r <= 1'b0;
    end else begin
      sum_r   <= sum_c;
      c_out_r <= c_out_c;
    end
  end

  // Serial accumulator: reset beats clear beats enable; word freezes when full
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r <= 1'b0;
      word_r  <= '0;
      count_r <= '0;
    end else if (bus.ser_clr) begin
      carry_r <= bus.c_in;
      word_r  <= '0;
      count_r <= '0;
    end else if (bus.ser_en && !full) begin
      carry_r <= ser_carry_c;
      word_r  <= {ser_sum_c, word_r[WORD_W-1:1]};
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign bus.sum       = sum_c;
  assign bus.c_out     = c_out_c;
  assign bus.ser_sum   = ser_sum_c;
  assign bus.sum_q     = sum_r;
  assign bus.c_out_q   = c_out_r;
  assign bus.carry_q   = carry_r;
  assign bus.ser_word  = word_r;
  assign bus.bit_count = count_r;
  assign bus.ser_done  = full;

endmodule

// File: tb/tb_one_bit_adder.sv
// Purpose: directed self-checking bench for the one-bit adder cell.
// Latency: samples 1 ns after each rising edge.
// Backpressure: none exercised; stimulus is fixed-length.
module tb_one_bit_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  one_bit_adder_if #(.WORD_W(W)) bus ();

  one_bit_adder #(.WORD_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock stays parked low until the combinational table has been checked
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic a;
    logic b;
    logic ci;
    logic s;
    logic co;
  } vec_t;

  vec_t tt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Seed with ser_clr, shift WORD_W operand bits, then check the result
  task automatic serial_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic seed, input logic [W-1:0] exp_word, input logic exp_carry);
    bus.ser_clr = 1'b1;
    bus.ser_en  = 1'b0;
    bus.c_in    = seed;
    tick();
    chk({name, "_seed"}, {31'd0, bus.carry_q}, {31'd0, seed});
    bus.ser_clr = 1'b0;
    bus.c_in    = 1'b0;
    for (int i = 0; i < W; i++) begin
      bus.in_1   = a[i];
      bus.in_2   = b[i];
      bus.ser_en = 1'b1;
      #1;
      chk($sformatf("%s_ser_sum%0d", name, i), {31'd0, bus.ser_sum}, {31'd0, exp_word[i]});
      tick();
    end
    bus.ser_en = 1'b0;
    chk({name, "_word"},  {24'd0, bus.ser_word}, {24'd0, exp_word});
    chk({name, "_carry"}, {31'd0, bus.carry_q},  {31'd0, exp_carry});
    chk({name, "_count"}, {28'd0, bus.bit_count}, 32'd8);
    chk({name, "_done"},  {31'd0, bus.ser_done}, 32'd1);
  endtask

  initial begin
    tt[0] = '{a:0, b:0, ci:0, s:0, co:0};
    tt[1] = '{a:0, b:0, ci:1, s:1, co:0};
    tt[2] = '{a:0, b:1, ci:0, s:1, co:0};
    tt[3] = '{a:0, b:1, ci:1, s:0, co:1};
    tt[4] = '{a:1, b:0, ci:0, s:1, co:0};
    tt[5] = '{a:1, b:0, ci:1, s:0, co:1};
    tt[6] = '{a:1, b:1, ci:0, s:0, co:1};
    tt[7] = '{a:1, b:1, ci:1, s:1, co:1};

    rst         = 1'b0;
    bus.in_1    = 1'b0;
    bus.in_2    = 1'b0;
    bus.c_in    = 1'b0;
    bus.ser_en  = 1'b0;
    bus.ser_clr = 1'b0;

    // Truth table with no clock edge ever having occurred
    for (int i = 0; i < 8; i++) begin
      bus.in_1 = tt[i].a;
      bus.in_2 = tt[i].b;
      bus.c_in = tt[i].ci;
      #10;
      chk($sformatf("tt_sum%0d", i),  {31'd0, bus.sum},   {31'd0, tt[i].s});
      chk($sformatf("tt_cout%0d", i), {31'd0, bus.c_out}, {31'd0, tt[i].co});
    end

    // Reset state
    clk_en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_sum_q",   {31'd0, bus.sum_q},     32'd0);
    chk("rst_c_out_q", {31'd0, bus.c_out_q},   32'd0);
    chk("rst_carry_q", {31'd0, bus.carry_q},   32'd0);
    chk("rst_word",    {24'd0, bus.ser_word},  32'd0);
    chk("rst_count",   {28'd0, bus.bit_count}, 32'd0);
    chk("rst_done",    {31'd0, bus.ser_done},  32'd0);
    rst = 1'b0;

    // Registered copy: 100 registers as sum=1,c=0; then 011 must not show before the edge
    bus.in_1 = 1'b1; bus.in_2 = 1'b0; bus.c_in = 1'b0;
    tick();
    chk("reg_prev_sum_q",   {31'd0, bus.sum_q},   32'd1);
    chk("reg_prev_c_out_q", {31'd0, bus.c_out_q}, 32'd0);
    bus.in_1 = 1'b0; bus.in_2 = 1'b1; bus.c_in = 1'b1;
    #2;
    chk("reg_hold_sum_q",   {31'd0, bus.sum_q},   32'd1);
    chk("reg_hold_c_out_q", {31'd0, bus.c_out_q}, 32'd0);
    tick();
    chk("reg_011_sum_q",   {31'd0, bus.sum_q},   32'd0);
    chk("reg_011_c_out_q", {31'd0, bus.c_out_q}, 32'd1);

    // Serial adds
    serial_add("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

    // ser_en low holds the finished word
    bus.in_1 = 1'b1; bus.in_2 = 1'b1;
    tick();
    chk("idle_word",  {24'd0, bus.ser_word}, 32'h96);

    serial_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

    // Ninth enable after saturation changes nothing
    bus.in_1 = 1'b1; bus.in_2 = 1'b1; bus.ser_en = 1'b1;
    tick();
    bus.ser_en = 1'b0;
    chk("sat_word",  {24'd0, bus.ser_word},  32'h00);
    chk("sat_carry", {31'd0, bus.carry_q},   32'd1);
    chk("sat_count", {28'd0, bus.bit_count}, 32'd8);
    chk("sat_done",  {31'd0, bus.ser_done},  32'd1);

    serial_add("seed1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // Reset mid-operation: 4 bits of 0xFF+0xFF leave carry=1, count=4
    bus.ser_clr = 1'b1; bus.c_in = 1'b0;
    tick();
    bus.ser_clr = 1'b0;
    bus.in_1 = 1'b1; bus.in_2 = 1'b1; bus.ser_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_count", {28'd0, bus.bit_count}, 32'd4);
    chk("mid_word",  {24'd0, bus.ser_word},  32'hE0);
    chk("mid_carry", {31'd0, bus.carry_q},   32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ser_en = 1'b0;
    chk("midrst_count", {28'd0, bus.bit_count}, 32'd0);
    chk("midrst_word",  {24'd0, bus.ser_word},  32'd0);
    chk("midrst_carry", {31'd0, bus.carry_q},   32'd0);
    chk("midrst_sum_q", {31'd0, bus.sum_q},     32'd0);
    chk("midrst_done",  {31'd0, bus.ser_done},  32'd0);

    // ser_clr alone seeds 1; together with rst the reset wins
    bus.in_1 = 1'b0; bus.in_2 = 1'b0;
    bus.ser_clr = 1'b1; bus.c_in = 1'b1;
    tick();
    chk("clr_seed1", {31'd0, bus.carry_q}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_clr_carry", {31'd0, bus.carry_q}, 32'd0);
    rst = 1'b0;
    bus.ser_clr = 1'b0;
    bus.c_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/one_bit_adder.md
# one_bit_adder

Single-bit full adder with a combinational sum/carry path, plus registered copies and a bit-serial accumulation mode for multi-bit adds. It is the carry-chain primitive of the MIPS processor datapath. The ALU uses it either as a pure combinational cell or as a clocked LSB-first serial adder with an internal carry flop and result shift register.

## Interface
- One clock; reset is synchronous and active-high.
- Parameter `WORD_W`, default 8: width of the serial result shift register and the bit-count saturation limit.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `in_1`  in  1  addend bit A.
- `in_2`  in  1  addend bit B.
- `c_in`  in  1  carry-in for the combinational path; also the serial carry seed on `ser_clr`.
- `ser_en`  in  1  advance serial add by one bit this cycle.
- `ser_clr`  in  1  start a new serial add; seeds the carry flop.
- `sum`  out  1  combinational sum = `in_1` ^ `in_2` ^ `c_in`.
- `c_out`  out  1  combinational carry = majority(`in_1`, `in_2`, `c_in`).
- `sum_q`  out  1  `sum` registered.
- `c_out_q`  out  1  `c_out` registered.
- `ser_sum`  out  1  combinational serial sum bit = `in_1` ^ `in_2` ^ `carry_q`.
- `carry_q`  out  1  serial carry flop.
- `ser_word`  out  `WORD_W`  serial result, shifted in LSB-first.
- `bit_count`  out  clog2(`WORD_W`+1)  bits accumulated, saturating at `WORD_W`.
- `ser_done`  out  1  high when `bit_count` == `WORD_W`.

## Operation
- **Combinational path.** `sum` and `c_out` are pure functions of `in_1`, `in_2` and `c_in`.
  - No dependence on `clk` or `rst`.
  - Must be valid without any clock edge ever occurring.
- **Registered copies.** On every rising edge, `sum_q` takes `sum` and `c_out_q` takes `c_out`.
- **Serial mode.** Priority order at each rising edge is `rst` > `ser_clr` > `ser_en`.
  - `rst`: all registers clear to 0 (`sum_q`, `c_out_q`, `carry_q`, `ser_word`, `bit_count`).
  - `ser_clr`: `carry_q` takes `c_in`; `ser_word` and `bit_count` clear to 0. The current bits are not accumulated.
  - `ser_en` with `bit_count` < `WORD_W`:
    - `carry_q` takes majority(`in_1`, `in_2`, `carry_q`).
    - `ser_word` takes {`ser_sum`, `ser_word`[WORD_W-1:1]} (shift right, new bit enters at the MSB).
    - `bit_count` increments.
    - After `WORD_W` bits, `ser_word`[0] holds the first-presented LSB.
  - `ser_en` with `bit_count` == `WORD_W`: no register changes. The word is frozen and `carry_q` holds the final carry-out.
  - `ser_en` low: serial state holds.
- `ser_sum` uses `carry_q`, not `c_in`, and is valid combinationally in the same cycle the operand bits are presented.

## Timing
- `sum`, `c_out` and `ser_sum`: zero-cycle combinational latency.
- `sum_q` and `c_out_q`: 1-cycle latency.
- Serial `WORD_W`-bit add:
  - Pulse `ser_clr` for 1 cycle.
  - Then assert `ser_en` for `WORD_W` cycles, presenting operand bit i in cycle i.
  - `ser_done` and the final `ser_word`/`carry_q` are visible the cycle after the last enabled edge.
- Reset asserted mid-serial-add clears all state on that edge. `ser_done` reads 0 afterward.
- `rst` and `ser_clr` in the same cycle: reset wins, and `carry_q` becomes 0 regardless of `c_in`.

## Test plan
- **Exhaustive truth table, no clock.** Drive all 8 (`in_1`, `in_2`, `c_in`) combinations for 10 ns each, e.g. 111 -> `sum`=1, `c_out`=1; 110 -> 0,1; 100 -> 1,0; 000 -> 0,0.
- **Registered copy.** Apply 011 and clock once -> `sum_q`=0, `c_out_q`=1. Before that edge, both still hold their prior values.
- **Serial add, no carry-out.** Seed `c_in`=0, then add 0x5A + 0x3C LSB-first over 8 enabled cycles -> `ser_word`=0x96, `carry_q`=0, `ser_done`=1.
- **Serial add, carry-out and saturation.** Add 0xFF + 0x01 -> `ser_word`=0x00, `carry_q`=1. A 9th `ser_en` leaves the word and `bit_count`=8 unchanged.
- **Seed carry.** Seed `c_in`=1, then add 0x00 + 0x00 -> `ser_word`=0x01, `carry_q`=0.
- **Reset mid-operation and priority.** After 4 enabled bits, assert `rst` -> all registers 0, `ser_done`=0. Assert `rst` and `ser_clr` together with `c_in`=1 -> `carry_q`=0.
